// File: rtl/timer_multi_channel.sv
// Multi-channel down-counting timer sharing one prescaler tick.
// Per channel: start/stop control, periodic or one-shot rollover, sticky flag.
module timer_multi_channel #(
    parameter int TIMER_WIDTH     = 16,
    parameter int NUM_CHANNELS    = 4,
    parameter int PRESCALER_WIDTH = 8
) (
    input  logic                                Clk_In,
    input  logic                                Reset_In,
    input  logic                                Enable_In,
    input  logic [PRESCALER_WIDTH-1:0]          Prescale_In,
    input  logic [NUM_CHANNELS-1:0]             Start_Timer_Command_In,
    input  logic [NUM_CHANNELS-1:0]             Stop_Timer_Command_In,
    input  logic [NUM_CHANNELS-1:0]             Timer_Periodic_Oneshotb_Mode_In,
    input  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] Preload_Timer_Value_In,
    input  logic [NUM_CHANNELS-1:0]             Clear_Rollover_In,
    input  logic [NUM_CHANNELS-1:0]             Interrupt_Mask_In,
    output logic [NUM_CHANNELS-1:0]             Timer_Running_Flag_Out,
    output logic [NUM_CHANNELS-1:0]             Timer_Rollover_Flag_Out,
    output logic [NUM_CHANNELS-1:0]             Timer_Rollover_Sticky_Out,
    output logic [NUM_CHANNELS*TIMER_WIDTH-1:0] Timer_Count_Out,
    output logic                                Interrupt_Out
);

    logic [PRESCALER_WIDTH-1:0]                presc_q, presc_d;
    logic                                      tick;
    logic [NUM_CHANNELS-1:0]                   run_q, run_d;
    logic [NUM_CHANNELS-1:0]                   pulse_q, pulse_d;
    logic [NUM_CHANNELS-1:0]                   sticky_q, sticky_d;
    logic [NUM_CHANNELS-1:0][TIMER_WIDTH-1:0]  cnt_q, cnt_d;
    logic                                      irq_q, irq_d;
    logic [NUM_CHANNELS-1:0]                   set_sticky;

    // Prescaler is held at zero while disabled so ticks restart cleanly.
    always_comb begin
        presc_d = '0;
        tick    = 1'b0;
        if (Enable_In) begin
            if (presc_q >= Prescale_In) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESCALER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        run_d      = run_q;
        cnt_d      = cnt_q;
        pulse_d    = '0;
        set_sticky = '0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (Start_Timer_Command_In[n] && !run_q[n]) begin
                run_d[n] = 1'b1;
                cnt_d[n] = Preload_Timer_Value_In[n*TIMER_WIDTH +: TIMER_WIDTH];
            end else if (Stop_Timer_Command_In[n] && run_q[n]) begin
                run_d[n] = 1'b0;
                cnt_d[n] = '0;
            end else if (run_q[n] && tick) begin
                if (cnt_q[n] == '0) begin
                    pulse_d[n]    = 1'b1;
                    set_sticky[n] = 1'b1;
                    // Mode and preload are sampled here, not at start.
                    if (Timer_Periodic_Oneshotb_Mode_In[n]) begin
                        cnt_d[n] = Preload_Timer_Value_In[n*TIMER_WIDTH +: TIMER_WIDTH];
                    end else begin
                        cnt_d[n] = '0;
                        run_d[n] = 1'b0;
                    end
                end else begin
                    cnt_d[n] = cnt_q[n] - TIMER_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        sticky_d = set_sticky | (sticky_q & ~Clear_Rollover_In);
        irq_d    = |(sticky_q & Interrupt_Mask_In);
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            presc_q  <= '0;
            run_q    <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            run_q    <= run_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    assign Timer_Running_Flag_Out    = run_q;
    assign Timer_Rollover_Flag_Out   = pulse_q;
    assign Timer_Rollover_Sticky_Out = sticky_q;
    assign Timer_Count_Out           = cnt_q;
    assign Interrupt_Out             = irq_q;

endmodule

// File: tb/tb_timer_multi_channel.sv
// Directed bench for timer_multi_channel: periodic, one-shot, prescale,
// start/stop priority, channel independence and async reset.
module tb_timer_multi_channel;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  presc;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  mode;
    logic [63:0] preload;
    logic [3:0]  clr;
    logic [3:0]  mask;
    logic [3:0]  run_o;
    logic [3:0]  pulse_o;
    logic [3:0]  sticky_o;
    logic [63:0] cnt_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;

    timer_multi_channel #(
        .TIMER_WIDTH(16),
        .NUM_CHANNELS(4),
        .PRESCALER_WIDTH(8)
    ) dut (
        .Clk_In(clk),
        .Reset_In(rst),
        .Enable_In(en),
        .Prescale_In(presc),
        .Start_Timer_Command_In(start),
        .Stop_Timer_Command_In(stop),
        .Timer_Periodic_Oneshotb_Mode_In(mode),
        .Preload_Timer_Value_In(preload),
        .Clear_Rollover_In(clr),
        .Interrupt_Mask_In(mask),
        .Timer_Running_Flag_Out(run_o),
        .Timer_Rollover_Flag_Out(pulse_o),
        .Timer_Rollover_Sticky_Out(sticky_o),
        .Timer_Count_Out(cnt_o),
        .Interrupt_Out(irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cnt(input int ch);
        return cnt_o[ch*16 +: 16];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_preload(input int ch, input logic [15:0] v);
        preload[ch*16 +: 16] = v;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; presc = 8'd0; start = '0; stop = '0;
        mode = '0; preload = '0; clr = '0; mask = '0;
        #1;
        n_cmp++;
        if (run_o !== 4'b0) begin n_err++; $display("FAIL reset_run got %b exp 0000", run_o); end
        n_cmp++;
        if (pulse_o !== 4'b0) begin n_err++; $display("FAIL reset_pulse got %b exp 0000", pulse_o); end
        n_cmp++;
        if (sticky_o !== 4'b0) begin n_err++; $display("FAIL reset_sticky got %b exp 0000", sticky_o); end
        n_cmp++;
        if (cnt_o !== 64'd0) begin n_err++; $display("FAIL reset_count got %h exp 0", cnt_o); end
        n_cmp++;
        if (irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq_o); end
        step(2);
        rst = 1'b0;
        step(3);
        n_cmp++;
        if (run_o !== 4'b0 || cnt_o !== 64'd0) begin
            n_err++; $display("FAIL idle_after_reset run %b cnt %h exp 0", run_o, cnt_o);
        end
    endtask

    task automatic test_periodic;
        set_preload(0, 16'd5);
        mode[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n_cmp++;
        if (run_o[0] !== 1'b1 || cnt(0) !== 16'd5) begin
            n_err++; $display("FAIL per_start run %b cnt %0d exp 1/5", run_o[0], cnt(0));
        end
        for (int k = 0; k < 3; k++) begin
            for (int v = 4; v >= 0; v--) begin
                step();
                n_cmp++;
                if (cnt(0) !== 16'(v) || pulse_o[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL per_count k%0d got %0d/%b exp %0d/0", k, cnt(0), pulse_o[0], v);
                end
            end
            step();
            n_cmp++;
            if (pulse_o[0] !== 1'b1 || cnt(0) !== 16'd5 || run_o[0] !== 1'b1) begin
                n_err++;
                $display("FAIL per_roll k%0d pulse %b cnt %0d run %b exp 1/5/1",
                         k, pulse_o[0], cnt(0), run_o[0]);
            end
        end
        stop[0] = 1'b1;
        step();
        stop[0] = 1'b0;
        n_cmp++;
        if (run_o[0] !== 1'b0 || cnt(0) !== 16'd0 || sticky_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL per_stop run %b cnt %0d sticky %b exp 0/0/1", run_o[0], cnt(0), sticky_o[0]);
        end
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
    endtask

    task automatic test_oneshot_enable;
        set_preload(2, 16'd3);
        mode[2] = 1'b0;
        mask[2] = 1'b1;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        n_cmp++;
        if (cnt(2) !== 16'd3) begin n_err++; $display("FAIL os_start cnt %0d exp 3", cnt(2)); end
        step();
        n_cmp++;
        if (cnt(2) !== 16'd2) begin n_err++; $display("FAIL os_cnt2 cnt %0d exp 2", cnt(2)); end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (cnt(2) !== 16'd2 || run_o[2] !== 1'b1) begin
                n_err++; $display("FAIL os_hold%0d cnt %0d run %b exp 2/1", i, cnt(2), run_o[2]);
            end
        end
        en = 1'b1;
        step();
        n_cmp++;
        if (cnt(2) !== 16'd1) begin n_err++; $display("FAIL os_cnt1 cnt %0d exp 1", cnt(2)); end
        step();
        n_cmp++;
        if (cnt(2) !== 16'd0 || pulse_o[2] !== 1'b0) begin
            n_err++; $display("FAIL os_cnt0 cnt %0d pulse %b exp 0/0", cnt(2), pulse_o[2]);
        end
        step();
        n_cmp++;
        if (pulse_o[2] !== 1'b1 || run_o[2] !== 1'b0 || cnt(2) !== 16'd0
            || sticky_o[2] !== 1'b1 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL os_roll pulse %b run %b cnt %0d sticky %b irq %b exp 1/0/0/1/0",
                     pulse_o[2], run_o[2], cnt(2), sticky_o[2], irq_o);
        end
        step();
        n_cmp++;
        if (irq_o !== 1'b1 || pulse_o[2] !== 1'b0) begin
            n_err++; $display("FAIL os_irq irq %b pulse %b exp 1/0", irq_o, pulse_o[2]);
        end
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        n_cmp++;
        if (sticky_o[2] !== 1'b0 || irq_o !== 1'b1) begin
            n_err++; $display("FAIL os_clr sticky %b irq %b exp 0/1", sticky_o[2], irq_o);
        end
        step();
        n_cmp++;
        if (irq_o !== 1'b0) begin n_err++; $display("FAIL os_irq_off irq %b exp 0", irq_o); end
        mask[2] = 1'b0;
    endtask

    task automatic test_prescale;
        logic [15:0] seq [3];
        int          s;
        seq[0] = 16'd1; seq[1] = 16'd0; seq[2] = 16'd2;
        presc = 8'd2;
        set_preload(1, 16'd2);
        mode[1] = 1'b1;
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        step();
        n_cmp++;
        if (cnt(1) !== 16'd2) begin n_err++; $display("FAIL ps_first cnt %0d exp 2", cnt(1)); end
        step();
        n_cmp++;
        if (cnt(1) !== 16'd1) begin n_err++; $display("FAIL ps_cnt1 cnt %0d exp 1", cnt(1)); end
        for (int i = 1; i <= 18; i++) begin
            step();
            s = i / 3;
            n_cmp++;
            if (cnt(1) !== seq[s % 3]
                || pulse_o[1] !== ((i % 3 == 0) && (s % 3 == 2))) begin
                n_err++;
                $display("FAIL ps_seq i%0d cnt %0d pulse %b exp %0d/%b", i, cnt(1), pulse_o[1],
                         seq[s % 3], ((i % 3 == 0) && (s % 3 == 2)));
            end
        end
        stop[1] = 1'b1;
        clr[1] = 1'b1;
        presc = 8'd0;
        step();
        stop[1] = 1'b0;
        clr[1] = 1'b0;
    endtask

    task automatic test_start_stop;
        set_preload(0, 16'd9);
        start[0] = 1'b1;
        stop[0] = 1'b1;
        step();
        n_cmp++;
        if (run_o[0] !== 1'b1 || cnt(0) !== 16'd9) begin
            n_err++; $display("FAIL ss_idle run %b cnt %0d exp 1/9", run_o[0], cnt(0));
        end
        step();
        start[0] = 1'b0;
        stop[0] = 1'b0;
        n_cmp++;
        if (run_o[0] !== 1'b0 || cnt(0) !== 16'd0 || pulse_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ss_run run %b cnt %0d pulse %b exp 0/0/0", run_o[0], cnt(0), pulse_o[0]);
        end
    endtask

    task automatic test_independent;
        set_preload(0, 16'd3);
        set_preload(3, 16'd7);
        mode[0] = 1'b1;
        mode[3] = 1'b1;
        mask = 4'b0000;
        clr = 4'b1111;
        step();
        clr = 4'b0000;
        start[0] = 1'b1;
        start[3] = 1'b1;
        step();
        start[0] = 1'b0;
        start[3] = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step();
            n_cmp++;
            if (pulse_o[0] !== (i % 4 == 0) || pulse_o[3] !== (i % 8 == 0) || irq_o !== 1'b0) begin
                n_err++;
                $display("FAIL ind i%0d pulse0 %b pulse3 %b irq %b exp %b/%b/0",
                         i, pulse_o[0], pulse_o[3], irq_o, (i % 4 == 0), (i % 8 == 0));
            end
        end
        n_cmp++;
        if (sticky_o[3] !== 1'b1 || irq_o !== 1'b0) begin
            n_err++; $display("FAIL ind_sticky sticky3 %b irq %b exp 1/0", sticky_o[3], irq_o);
        end
        stop = 4'b1111;
        step();
        stop = 4'b0000;
    endtask

    task automatic test_async_reset;
        set_preload(0, 16'd5);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step(2);
        n_cmp++;
        if (cnt(0) !== 16'd3 || run_o[0] !== 1'b1) begin
            n_err++; $display("FAIL ar_pre cnt %0d run %b exp 3/1", cnt(0), run_o[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (run_o !== 4'b0 || cnt_o !== 64'd0 || pulse_o !== 4'b0
            || sticky_o !== 4'b0 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL ar_mid run %b cnt %h pulse %b sticky %b irq %b exp all 0",
                     run_o, cnt_o, pulse_o, sticky_o, irq_o);
        end
        @(negedge clk);
        rst = 1'b0;
        step(4);
        n_cmp++;
        if (run_o !== 4'b0 || cnt_o !== 64'd0 || pulse_o !== 4'b0) begin
            n_err++; $display("FAIL ar_idle run %b cnt %h pulse %b exp 0", run_o, cnt_o, pulse_o);
        end
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n_cmp++;
        if (run_o[0] !== 1'b1 || cnt(0) !== 16'd5) begin
            n_err++; $display("FAIL ar_restart run %b cnt %0d exp 1/5", run_o[0], cnt(0));
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot_enable();
        test_prescale();
        test_start_stop();
        test_independent();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_multi_channel.md
TIMER_MULTI_CHANNEL -- requirements
Module: Timer_Multi_Channel

Interface
REQ-001 Parameter TIMER_WIDTH, 16: width of each channel's down-counter.
REQ-002 Parameter NUM_CHANNELS, 4: number of independent timer channels.
REQ-003 Parameter PRESCALER_WIDTH, 8: width of the shared prescaler compare value.
REQ-004 Clk_In  in  1: single clock; all state changes on its rising edge.
REQ-005 Reset_In  in  1: asynchronous, active-high reset.
REQ-006 Enable_In  in  1: global count enable; low pauses prescaler and all counters.
REQ-007 Prescale_In  in  PRESCALER_WIDTH: tick every Prescale_In+1 enabled clocks.
REQ-008 Start_Timer_Command_In  in  NUM_CHANNELS: per-channel start, level-sampled.
REQ-009 Stop_Timer_Command_In  in  NUM_CHANNELS: per-channel stop, level-sampled.
REQ-010 Timer_Periodic_Oneshotb_Mode_In  in  NUM_CHANNELS: 1 periodic, 0 one-shot.
REQ-011 Preload_Timer_Value_In  in  NUM_CHANNELS*TIMER_WIDTH: channel n at bits [n*TIMER_WIDTH +: TIMER_WIDTH].
REQ-012 Clear_Rollover_In  in  NUM_CHANNELS: write-1-to-clear for sticky flags.
REQ-013 Interrupt_Mask_In  in  NUM_CHANNELS: 1 enables channel into Interrupt_Out.
REQ-014 Timer_Running_Flag_Out  out  NUM_CHANNELS: channel running.
REQ-015 Timer_Rollover_Flag_Out  out  NUM_CHANNELS: one-cycle rollover pulse.
REQ-016 Timer_Rollover_Sticky_Out  out  NUM_CHANNELS: latched rollover status.
REQ-017 Timer_Count_Out  out  NUM_CHANNELS*TIMER_WIDTH: current counts, same packing as preload.
REQ-018 Interrupt_Out  out  1: OR of (sticky AND mask) across channels, registered.

Function
REQ-019 All outputs SHALL be registered and always driven (no tri-state).
REQ-020 Prescaler: counter SHALL reset to 0 while Enable_In=0; when enabled, tick=1 if counter >= Prescale_In, counter then wraps to 0, else counter increments; Prescale_In=0 gives tick every cycle.
REQ-021 Per-channel priority each edge: start-while-idle > stop > tick-count > hold.
REQ-022 Start (Start=1, Running=0): next cycle Running=1, Count=preload, pulse=0; independent of Enable_In and tick; Start while Running SHALL be ignored.
REQ-023 Stop while running: next cycle Running=0, Count=0, pulse=0; sticky unchanged; independent of Enable_In.
REQ-024 Running, tick=1, Count>0: Count decrements by 1, pulse=0.
REQ-025 Running, tick=1, Count=0: pulse=1 for one cycle, sticky set; periodic mode reloads Count=current preload and stays running; one-shot mode sets Count=0, Running=0.
REQ-026 Mode and preload SHALL be sampled at the rollover edge, not latched at start.
REQ-027 Preload=0 periodic: rollover on every tick.
REQ-028 Running, tick=0 or Enable_In=0: Count, Running held; pulse=0.
REQ-029 Idle, no start: Count=0, pulse=0.
REQ-030 Sticky: set and Clear_Rollover_In on the same edge -> set wins; clear alone -> 0 next cycle.
REQ-031 Interrupt_Out SHALL update one cycle after sticky/mask change.
REQ-032 Channels SHALL be fully independent apart from the shared prescaler tick and Enable_In.

Reset
REQ-033 Reset_In=1 SHALL immediately clear prescaler, all Count, Running, pulse, sticky, Interrupt_Out to 0, regardless of clock, including mid-count.
REQ-034 After Reset_In falls, channels SHALL stay idle until a start command.

Verification (TIMER_WIDTH=16, NUM_CHANNELS=4, PRESCALER_WIDTH=8)
REQ-035 Prescale=0, ch0 periodic, preload 5, start 1 cycle -> Count 5,4,3,2,1,0, then pulse=1 with Count=5; period 6 cycles, repeats 3x, Running stays 1.
REQ-036 ch2 one-shot, preload 3, Enable_In low 2 cycles at Count=2 -> Count holds 2, resumes 1,0; pulse=1, Running=0, Count=0; sticky=1; mask=1 -> Interrupt_Out=1 next cycle; Clear_Rollover_In[2] -> sticky 0, Interrupt_Out 0.
REQ-037 Prescale=2, ch1 periodic, preload 2 -> each count value held exactly 3 cycles in steady state; rollover every 9 cycles.
REQ-038 Start+stop same cycle on idle ch0 -> Running=1, Count=preload; same on running ch0 -> Running=0, Count=0, pulse=0.
REQ-039 ch0 preload 3, ch3 preload 7, both periodic, mask ch3=0 -> independent pulse periods 4 and 8; sticky[3]=1 never raises Interrupt_Out.
REQ-040 Reset_In asserted mid-clock with ch0 Count=3 running -> all outputs 0 before next edge; no activity after release until start.
